// File: rtl/mips_avalon_arbiter.sv
// mips_avalon_arbiter: shares one Avalon-MM memory slave between the MIPS
// instruction-fetch master and data master, one transaction at a time.
// The grant is held in a registered FSM (IDLE / GRANT_I / GRANT_D). While a
// master is granted, its request is mirrored onto the slave and the slave's
// waitrequest is passed back to it. A stall watchdog sets a sticky timeout
// flag, and a sticky protocol_err flag records a granted master that dropped
// its request before completion.
// Optional feature macro: ARB_ROUND_ROBIN_EN. When it is defined, a
// simultaneous request in IDLE goes to the master that was not granted last.
// When it is undefined, the data master always wins.
module mips_avalon_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd1024
) (
    input  logic        clk,
    input  logic        reset,
    // instruction master
    input  logic [31:0] i_address,
    input  logic        i_read,
    output logic        i_waitrequest,
    output logic [31:0] i_readdata,
    // data master
    input  logic [31:0] d_address,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_writedata,
    input  logic [3:0]  d_byteenable,
    output logic        d_waitrequest,
    output logic [31:0] d_readdata,
    // memory slave
    output logic [31:0] s_address,
    output logic        s_read,
    output logic        s_write,
    output logic [31:0] s_writedata,
    output logic [3:0]  s_byteenable,
    input  logic        s_waitrequest,
    input  logic [31:0] s_readdata,
    // sticky status
    output logic        timeout,
    output logic        protocol_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 32'd1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(32'd0);

    // last_grant encoding
    localparam logic LG_I = 1'b0;
    localparam logic LG_D = 1'b1;

`ifdef ARB_ROUND_ROBIN_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             timeout_q, timeout_d;
    logic             protocol_err_q, protocol_err_d;

    logic             d_req_s;
    logic             gnt_req_s;
    logic             pick_i_s;

    assign d_req_s = d_read | d_write;

    // Request of whichever master currently owns the slave (0 in IDLE).
    always_comb begin
        gnt_req_s = 1'b0;
        case (state_q)
            GRANT_I: gnt_req_s = i_read;
            GRANT_D: gnt_req_s = d_req_s;
            default: gnt_req_s = 1'b0;
        endcase
    end

    // On a tie the instruction master wins only under round-robin after a data grant.
    always_comb begin
        if (RR_EN && (last_grant_q == LG_D)) begin
            pick_i_s = 1'b1;
        end else begin
            pick_i_s = 1'b0;
        end
    end

    // Next-state, last-grant, stall counter and sticky flag computation.
    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        stall_cnt_d    = stall_cnt_q;
        timeout_d      = timeout_q;
        protocol_err_d = protocol_err_q;
        case (state_q)
            IDLE: begin
                stall_cnt_d = CNT_ZERO;
                if (d_req_s && i_read) begin
                    state_d = pick_i_s ? GRANT_I : GRANT_D;
                end else if (d_req_s) begin
                    state_d = GRANT_D;
                end else if (i_read) begin
                    state_d = GRANT_I;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT_I, GRANT_D: begin
                if (!gnt_req_s) begin
                    // master abandoned its transaction; do not forward it again
                    state_d        = IDLE;
                    protocol_err_d = 1'b1;
                end else if (!s_waitrequest) begin
                    state_d      = IDLE;
                    last_grant_d = (state_q == GRANT_D) ? LG_D : LG_I;
                end else begin
                    // stalled: count towards the watchdog, keep the grant
                    if (stall_cnt_q < CNT_MAX) begin
                        stall_cnt_d = stall_cnt_q + CNT_ONE;
                    end else begin
                        stall_cnt_d = stall_cnt_q;
                    end
                    if (stall_cnt_q >= CNT_LAST) begin
                        timeout_d = 1'b1;
                    end else begin
                        timeout_d = timeout_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            last_grant_q   <= LG_I;
            stall_cnt_q    <= CNT_ZERO;
            timeout_q      <= 1'b0;
            protocol_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            stall_cnt_q    <= stall_cnt_d;
            timeout_q      <= timeout_d;
            protocol_err_q <= protocol_err_d;
        end
    end

    // Bus steering: the registered grant selects which master drives the slave.
    always_comb begin
        s_address     = 32'h0000_0000;
        s_read        = 1'b0;
        s_write       = 1'b0;
        s_writedata   = 32'h0000_0000;
        s_byteenable  = 4'h0;
        i_waitrequest = 1'b1;
        d_waitrequest = 1'b1;
        case (state_q)
            GRANT_I: begin
                s_address     = i_address;
                s_read        = i_read;
                s_write       = 1'b0;
                s_byteenable  = 4'hF;
                i_waitrequest = s_waitrequest;
            end
            GRANT_D: begin
                s_address     = d_address;
                s_read        = d_read;
                s_write       = d_write;
                s_writedata   = d_writedata;
                s_byteenable  = d_byteenable;
                d_waitrequest = s_waitrequest;
            end
            default: begin
                s_address     = 32'h0000_0000;
                i_waitrequest = 1'b1;
                d_waitrequest = 1'b1;
            end
        endcase
    end

    // Read data is broadcast; each master qualifies it with its own waitrequest.
    assign i_readdata   = s_readdata;
    assign d_readdata   = s_readdata;
    assign timeout      = timeout_q;
    assign protocol_err = protocol_err_q;

endmodule
